// File: rtl/sensor_debounce_encoder.sv
// sensor_debounce_encoder: synchronise, debounce and event-encode raw sensor lines
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          conditioning enable (0 freezes counters and clean levels)
//   ui           raw asynchronous sensor lines
//   sensor_clean debounced sensor levels
//   event_valid  event word available
//   event_ready  consumer accepts the event when high with event_valid
//   event_chan   channel of the current event
//   event_rise   1 = clean level rose, 0 = fell
//   overflow     sticky flag: an event was merged into an unread pending one
module sensor_debounce_encoder #(
    parameter int DEBOUNCE = 4,
    parameter int NCH      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [NCH-1:0] ui,
    output logic [NCH-1:0] sensor_clean,
    output logic           event_valid,
    input  logic           event_ready,
    output logic [2:0]     event_chan,
    output logic           event_rise,
    output logic           overflow
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [NCH-1:0] sync1, sync2, clean, toggle;
    logic [NCH-1:0] rise_pend, fall_pend, rise_set, fall_set, rise_take, fall_take;
    logic [CW-1:0]  cnt   [NCH];
    logic [CW-1:0]  cnt_n [NCH];
    logic [2:0]     sel;
    logic           sel_rise, any_pend, load, ovf_hit;

    assign sensor_clean = clean;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_n[i] = (!ena) ? cnt[i] :
                       (sync2[i] == clean[i] || cnt[i] == LAST) ? '0 : cnt[i] + CW'(1);
            toggle[i] = ena && sync2[i] != clean[i] && cnt[i] == LAST;
        end
    end

    // Scan downward so the lowest pending channel wins; rise beats fall.
    always_comb begin
        sel      = '0;
        sel_rise = 1'b0;
        any_pend = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rise_pend[i] || fall_pend[i]) begin
                sel      = 3'(i);
                sel_rise = rise_pend[i];
                any_pend = 1'b1;
            end
        end
    end

    assign load      = !event_valid || event_ready;
    assign rise_set  = toggle & ~clean;
    assign fall_set  = toggle & clean;
    assign rise_take = (load && any_pend && sel_rise)  ? NCH'(1) << sel : '0;
    assign fall_take = (load && any_pend && !sel_rise) ? NCH'(1) << sel : '0;
    // A bit being loaded out in the same cycle it is re-set is not a loss.
    assign ovf_hit   = |((rise_set & rise_pend & ~rise_take) | (fall_set & fall_pend & ~fall_take));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            clean       <= '0;
            cnt         <= '{default: '0};
            rise_pend   <= '0;
            fall_pend   <= '0;
            overflow    <= 1'b0;
            event_valid <= 1'b0;
            event_chan  <= '0;
            event_rise  <= 1'b0;
        end else begin
            sync1     <= ui;
            sync2     <= sync1;
            clean     <= clean ^ toggle;
            cnt       <= cnt_n;
            rise_pend <= (rise_pend & ~rise_take) | rise_set;
            fall_pend <= (fall_pend & ~fall_take) | fall_set;
            overflow  <= overflow || ovf_hit;
            if (load) begin
                event_valid <= any_pend;
                if (any_pend) begin
                    event_chan <= sel;
                    event_rise <= sel_rise;
                end
            end
        end
    end
endmodule

// File: tb/tb_sensor_debounce_encoder.sv
// tb_sensor_debounce_encoder: directed self-checking bench for sensor_debounce_encoder
module tb_sensor_debounce_encoder;
    logic       clk = 1'b0;
    logic       rst_n, ena, event_ready;
    logic [7:0] ui, sensor_clean;
    logic       event_valid, event_rise, overflow;
    logic [2:0] event_chan;
    int         n_cmp = 0;
    int         n_err = 0;

    sensor_debounce_encoder dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui(ui), .sensor_clean(sensor_clean),
        .event_valid(event_valid), .event_ready(event_ready), .event_chan(event_chan),
        .event_rise(event_rise), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui    = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; event_ready = 1'b0; ui = 8'hFF;
        tick(1);
        n_cmp++; if ({sensor_clean, event_valid, event_chan, event_rise, overflow} !== 14'h0) begin n_err++; $display("FAIL reset_outputs got clean=%h v=%b ch=%0d r=%b ov=%b want all 0", sensor_clean, event_valid, event_chan, event_rise, overflow); end
        rst_n = 1'b1;
        tick(5);
        n_cmp++; if (sensor_clean !== 8'h00) begin n_err++; $display("FAIL reset_edge5 clean got %h want 00", sensor_clean); end
        tick(1);
        n_cmp++; if (sensor_clean !== 8'hFF) begin n_err++; $display("FAIL reset_edge6 clean got %h want ff", sensor_clean); end
        n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL reset_edge6 valid got %b want 0", event_valid); end
        event_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            n_cmp++; if ({event_valid, event_chan, event_rise} !== {1'b1, 3'(k), 1'b1}) begin n_err++; $display("FAIL reset_drain%0d got v=%b ch=%0d r=%b want v=1 ch=%0d r=1", k, event_valid, event_chan, event_rise, k); end
        end
        tick(1);
        n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL reset_drain_end valid got %b want 0", event_valid); end
    endtask

    task automatic test_single();
        do_reset();
        event_ready = 1'b1;
        ui = 8'h01;
        tick(5);
        n_cmp++; if (sensor_clean !== 8'h00) begin n_err++; $display("FAIL single_rise_edge5 clean got %h want 00", sensor_clean); end
        tick(1);
        n_cmp++; if (sensor_clean !== 8'h01) begin n_err++; $display("FAIL single_rise_edge6 clean got %h want 01", sensor_clean); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_000_1) begin n_err++; $display("FAIL single_rise_event got v=%b ch=%0d r=%b want v=1 ch=0 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL single_rise_done valid got %b want 0", event_valid); end
        tick(2);
        ui = 8'h00;
        tick(5);
        n_cmp++; if (sensor_clean !== 8'h01) begin n_err++; $display("FAIL single_fall_edge5 clean got %h want 01", sensor_clean); end
        tick(1);
        n_cmp++; if (sensor_clean !== 8'h00) begin n_err++; $display("FAIL single_fall_edge6 clean got %h want 00", sensor_clean); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_000_0) begin n_err++; $display("FAIL single_fall_event got v=%b ch=%0d r=%b want v=1 ch=0 r=0", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL single_fall_done valid got %b want 0", event_valid); end
    endtask

    task automatic test_glitch();
        ui = 8'h04;
        tick(3);
        ui = 8'h00;
        for (int k = 0; k < 10; k++) begin
            n_cmp++; if ({sensor_clean, event_valid, overflow} !== 10'h0) begin n_err++; $display("FAIL glitch_cycle%0d got clean=%h v=%b ov=%b want 00 0 0", k, sensor_clean, event_valid, overflow); end
            tick(1);
        end
    endtask

    task automatic test_simultaneous();
        event_ready = 1'b1;
        ui = 8'h06;
        tick(6);
        n_cmp++; if (sensor_clean !== 8'h06) begin n_err++; $display("FAIL simul_clean got %h want 06", sensor_clean); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_001_1) begin n_err++; $display("FAIL simul_first got v=%b ch=%0d r=%b want v=1 ch=1 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_010_1) begin n_err++; $display("FAIL simul_second got v=%b ch=%0d r=%b want v=1 ch=2 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL simul_done valid got %b want 0", event_valid); end
    endtask

    task automatic test_enable();
        do_reset();
        event_ready = 1'b1;
        ena = 1'b0;
        ui = 8'h20;
        tick(10);
        n_cmp++; if ({sensor_clean, event_valid} !== 9'h0) begin n_err++; $display("FAIL enable_frozen got clean=%h v=%b want 00 0", sensor_clean, event_valid); end
        ena = 1'b1;
        tick(3);
        n_cmp++; if (sensor_clean !== 8'h00) begin n_err++; $display("FAIL enable_edge3 clean got %h want 00", sensor_clean); end
        tick(1);
        n_cmp++; if (sensor_clean !== 8'h20) begin n_err++; $display("FAIL enable_edge4 clean got %h want 20", sensor_clean); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_101_1) begin n_err++; $display("FAIL enable_event got v=%b ch=%0d r=%b want v=1 ch=5 r=1", event_valid, event_chan, event_rise); end
    endtask

    task automatic test_overflow();
        do_reset();
        event_ready = 1'b0;
        ui = 8'h08;
        tick(6);
        n_cmp++; if (sensor_clean !== 8'h08) begin n_err++; $display("FAIL ovf_rise1 clean got %h want 08", sensor_clean); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_011_1) begin n_err++; $display("FAIL ovf_first_load got v=%b ch=%0d r=%b want v=1 ch=3 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        ui = 8'h00;
        tick(6);
        n_cmp++; if (sensor_clean !== 8'h00) begin n_err++; $display("FAIL ovf_fall1 clean got %h want 00", sensor_clean); end
        tick(2);
        ui = 8'h08;
        tick(6);
        n_cmp++; if (sensor_clean !== 8'h08) begin n_err++; $display("FAIL ovf_rise2 clean got %h want 08", sensor_clean); end
        tick(2);
        ui = 8'h00;
        tick(5);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b want 0", overflow); end
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_011_1) begin n_err++; $display("FAIL ovf_hold got v=%b ch=%0d r=%b want v=1 ch=3 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if ({sensor_clean, overflow} !== 9'h001) begin n_err++; $display("FAIL ovf_set got clean=%h ov=%b want 00 1", sensor_clean, overflow); end
        tick(2);
        event_ready = 1'b1;
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_011_1) begin n_err++; $display("FAIL ovf_drain_rise got v=%b ch=%0d r=%b want v=1 ch=3 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_011_0) begin n_err++; $display("FAIL ovf_drain_fall got v=%b ch=%0d r=%b want v=1 ch=3 r=0", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if ({event_valid, overflow} !== 2'b01) begin n_err++; $display("FAIL ovf_drain_end got v=%b ov=%b want v=0 ov=1", event_valid, overflow); end
    endtask

    task automatic test_reset_mid();
        event_ready = 1'b1;
        ui = 8'h10;
        tick(4);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({sensor_clean, event_valid, overflow} !== 10'h0) begin n_err++; $display("FAIL midrst_async got clean=%h v=%b ov=%b want 00 0 0", sensor_clean, event_valid, overflow); end
        #2;
        rst_n = 1'b1;
        tick(5);
        n_cmp++; if ({sensor_clean, event_valid} !== 9'h0) begin n_err++; $display("FAIL midrst_edge5 got clean=%h v=%b want 00 0", sensor_clean, event_valid); end
        tick(1);
        n_cmp++; if ({sensor_clean, event_valid} !== {8'h10, 1'b0}) begin n_err++; $display("FAIL midrst_edge6 got clean=%h v=%b want 10 0", sensor_clean, event_valid); end
        tick(1);
        n_cmp++; if ({event_valid, event_chan, event_rise} !== 5'b1_100_1) begin n_err++; $display("FAIL midrst_event got v=%b ch=%0d r=%b want v=1 ch=4 r=1", event_valid, event_chan, event_rise); end
        tick(1);
        n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL midrst_single got valid %b want 0", event_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_simultaneous();
        test_enable();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
